// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_pkg : VGA timing and TIA source constants (shared)       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package vga_timing_pkg;
  localparam int H_DISPLAY         = 640;
  localparam int H_MAX             = 799;
  localparam int V_DISPLAY         = 480;
  localparam int V_SYNC_START      = 490;
  localparam int SRC_WIDTH         = 160;
  localparam int COLOR_BITS        = 7;
  localparam int PIXEL_REPEAT_LOG2 = 2;
endpackage
`default_nettype wire

// File: rtl/line_buffer_2p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_2p : ping-pong line RAM, 1 write port, registered read  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module line_buffer_2p
  import vga_timing_pkg::*;
#(
  parameter int DEPTH  = SRC_WIDTH,
  parameter int DATA_W = COLOR_BITS
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH):0]     i_waddr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [$clog2(DEPTH):0]     i_raddr,
  output logic [DATA_W-1:0]          o_rdata
);
  localparam int c_idx_w = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [0:1][0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Address MSB selects the half; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr[c_idx_w]][i_waddr[c_idx_w-1:0]] <= i_wdata;
    r_rdata <= r_mem[i_raddr[c_idx_w]][i_raddr[c_idx_w-1:0]];
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/vga_scan_doubler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_scan_doubler : TIA 160-px line -> two 640-px VGA lines + vsync  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module vga_scan_doubler
  import vga_timing_pkg::*;
#(
  parameter int SRC_WIDTH         = vga_timing_pkg::SRC_WIDTH,
  parameter int PIXEL_REPEAT_LOG2 = vga_timing_pkg::PIXEL_REPEAT_LOG2,
  parameter int COLOR_BITS        = vga_timing_pkg::COLOR_BITS,
  parameter int H_DISPLAY         = vga_timing_pkg::H_DISPLAY,
  parameter int H_MAX             = vga_timing_pkg::H_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_pixel_valid,
  input  logic [COLOR_BITS-1:0] src_color,
  input  logic                  src_hblank,
  input  logic                  src_vsync,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  display_on,
  output logic [COLOR_BITS-1:0] pixel_color,
  output logic                  pixel_valid,
  output logic                  force_vsync
);
  localparam int                c_idx_w     = $clog2(SRC_WIDTH);
  localparam int                c_ptr_w     = $clog2(SRC_WIDTH + 1);
  localparam logic [c_ptr_w-1:0] c_src_width = c_ptr_w'(SRC_WIDTH);
  localparam logic [9:0]        c_h_display = 10'(H_DISPLAY);
  localparam logic [9:0]        c_h_max     = 10'(H_MAX);

  logic               r_hblank_d;
  logic               r_vsync_d;
  logic               r_commit;
  logic               r_vsync_rise;
  logic               r_wr_sel;
  logic               r_rd_sel;
  logic               r_disp_sel;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic               r_line_ready;
  logic               r_force_vsync;
  logic               r_pixel_valid;

  logic                  w_we;
  logic                  w_line_end;
  logic [c_idx_w-1:0]    w_rd_idx;
  logic [c_idx_w:0]      w_waddr;
  logic [c_idx_w:0]      w_raddr;
  logic [COLOR_BITS-1:0] w_rdata;
  logic                  w_unused_vpos;

  assign w_we       = src_pixel_valid & ~src_hblank & (r_wr_ptr < c_src_width);
  assign w_line_end = (hpos == c_h_max);
  assign w_rd_idx   = (hpos < c_h_display) ? c_idx_w'(hpos >> PIXEL_REPEAT_LOG2) : '0;
  assign w_waddr    = {r_wr_sel, c_idx_w'(r_wr_ptr)};
  assign w_raddr    = {r_disp_sel, w_rd_idx};
  assign w_unused_vpos = ^vpos;

  // Edge pulses are registered, so commit/vsync act one cycle after the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hblank_d   <= 1'b0;
      r_vsync_d    <= 1'b0;
      r_commit     <= 1'b0;
      r_vsync_rise <= 1'b0;
    end else begin
      r_hblank_d   <= src_hblank;
      r_vsync_d    <= src_vsync;
      r_commit     <= src_hblank & ~r_hblank_d;
      r_vsync_rise <= src_vsync & ~r_vsync_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel      <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_disp_sel    <= 1'b0;
      r_wr_ptr      <= '0;
      r_line_ready  <= 1'b0;
      r_force_vsync <= 1'b0;
      r_pixel_valid <= 1'b0;
    end else begin
      if (r_commit || r_vsync_rise)
        r_wr_ptr <= '0;
      else if (w_we)
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);

      if (r_commit) begin
        r_rd_sel     <= r_wr_sel;
        r_wr_sel     <= ~r_wr_sel;
        r_line_ready <= 1'b1;
      end

      // Swap only at end of line so a displayed line is never torn mid-scan.
      if (w_line_end)
        r_disp_sel <= r_rd_sel;

      if (r_force_vsync && w_line_end)
        r_force_vsync <= 1'b0;
      else if (r_vsync_rise)
        r_force_vsync <= 1'b1;

      r_pixel_valid <= display_on & r_line_ready;
    end
  end

  line_buffer_2p #(
    .DEPTH  (SRC_WIDTH),
    .DATA_W (COLOR_BITS)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (src_color),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign pixel_color = r_pixel_valid ? w_rdata : '0;
  assign pixel_valid = r_pixel_valid;
  assign force_vsync = r_force_vsync;
endmodule
`default_nettype wire

// File: tb/tb_vga_scan_doubler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_scan_doubler : random TIA lines vs line-doubling reference   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_vga_scan_doubler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src_pixel_valid = 1'b0;
  logic [6:0] src_color = 7'd0;
  logic       src_hblank = 1'b0;
  logic       src_vsync = 1'b0;
  logic [9:0] hpos = 10'd0;
  logic [9:0] vpos = 10'd0;
  logic       display_on = 1'b1;
  logic [6:0] pixel_color;
  logic       pixel_valid;
  logic       force_vsync;

  int checks = 0;
  int errors = 0;

  vga_scan_doubler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_pixel_valid (src_pixel_valid),
    .src_color       (src_color),
    .src_hblank      (src_hblank),
    .src_vsync       (src_vsync),
    .hpos            (hpos),
    .vpos            (vpos),
    .display_on      (display_on),
    .pixel_color     (pixel_color),
    .pixel_valid     (pixel_valid),
    .force_vsync     (force_vsync)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endfunction

  // Reference: two line stores; the one being filled, the most recently
  // committed one, and the one on screen (latched at each VGA line end).
  typedef struct {logic [6:0] color; logic valid; logic fv;} exp_t;
  exp_t       exp_q[$];
  logic [6:0] m_line [2][160];
  int         m_fill_buf, m_latest, m_shown, m_fill;
  bit         m_ready, m_fv, m_hb_prev, m_vs_prev, m_commit_due, m_vsync_due;

  function automatic void model_reset();
    m_fill_buf = 0; m_latest = 0; m_shown = 0; m_fill = 0;
    m_ready = 0; m_fv = 0; m_hb_prev = 0; m_vs_prev = 0;
    m_commit_due = 0; m_vsync_due = 0;
  endfunction

  always @(negedge rst_n) begin
    model_reset();
    if (exp_q.size() > 0)
      exp_q[exp_q.size()-1] = '{color: 7'd0, valid: 1'b0, fv: 1'b0};
  end

  always @(posedge clk) begin
    exp_t e;
    int   idx;
    if (!rst_n) begin
      model_reset();
      e = '{color: 7'd0, valid: 1'b0, fv: 1'b0};
    end else begin
      idx     = (hpos < 10'd640) ? int'(hpos) / 4 : 0;
      e.valid = display_on && m_ready;
      e.color = e.valid ? m_line[m_shown][idx] : 7'd0;
      if (src_pixel_valid && !src_hblank && m_fill < 160) begin
        m_line[m_fill_buf][m_fill] = src_color;
        m_fill++;
      end
      if (hpos == 10'd799) m_shown = m_latest;
      if (m_commit_due) begin
        m_latest   = m_fill_buf;
        m_fill_buf = 1 - m_fill_buf;
        m_fill     = 0;
        m_ready    = 1;
      end
      if (m_vsync_due) m_fill = 0;
      if (m_fv && hpos == 10'd799) m_fv = 0;
      else if (m_vsync_due)        m_fv = 1;
      m_commit_due = src_hblank && !m_hb_prev;
      m_vsync_due  = src_vsync && !m_vs_prev;
      m_hb_prev    = src_hblank;
      m_vs_prev    = src_vsync;
      e.fv = m_fv;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pixel_valid", {31'd0, pixel_valid}, {31'd0, e.valid});
      check("pixel_color", {25'd0, pixel_color}, {25'd0, e.color});
      check("force_vsync", {31'd0, force_vsync}, {31'd0, e.fv});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    hpos = (hpos == 10'd799) ? 10'd0 : hpos + 10'd1;
    if (hpos == 10'd0) vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
    display_on = (hpos < 10'd640);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_hpos(input int h);
    int guard = 0;
    while (int'(hpos) != h && guard < 900) begin
      tick();
      guard++;
    end
  endtask

  task automatic send_pixels(input int n, input bit ramp, input int gap_max);
    src_hblank = 1'b0;
    for (int i = 0; i < n; i++) begin
      src_pixel_valid = 1'b1;
      src_color = ramp ? 7'(i & 'h7f) : 7'($urandom);
      tick();
      src_pixel_valid = 1'b0;
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    src_pixel_valid = 1'b0;
  endtask

  task automatic hblank(input int len, input bit with_vsync);
    src_hblank = 1'b1;
    src_vsync  = with_vsync;
    for (int i = 0; i < len; i++) begin
      src_pixel_valid = 1'($urandom_range(0, 1));
      src_color = 7'($urandom);
      tick();
    end
    src_pixel_valid = 1'b0;
    src_hblank = 1'b0;
    src_vsync  = 1'b0;
  endtask

  task automatic vsync_pulse(input int len);
    src_vsync = 1'b1;
    idle(len);
    src_vsync = 1'b0;
  endtask

  initial begin
    idle(4);
    rst_n = 1'b1;
    idle(800);

    send_pixels(160, 1'b1, 0);
    hblank(20, 1'b0);
    idle(1700);

    send_pixels(200, 1'b1, 0);
    hblank(20, 1'b0);
    idle(1700);

    wait_hpos(99);
    vsync_pulse(2);
    idle(4);
    check("force_vsync set", {31'd0, force_vsync}, 32'd1);
    wait_hpos(500);
    vsync_pulse(2);
    wait_hpos(10);
    check("force_vsync cleared", {31'd0, force_vsync}, 32'd0);

    send_pixels(50, 1'b0, 1);
    vsync_pulse(3);
    send_pixels(30, 1'b0, 1);
    hblank(10, 1'b0);
    idle(1000);

    send_pixels(160, 1'b0, 0);
    wait_hpos(297);
    hblank(30, 1'b0);
    idle(1700);

    for (int l = 0; l < 14; l++) begin
      int np;
      int kind;
      np   = $urandom_range(0, 200);
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        send_pixels(np / 2, 1'b0, 1);
        vsync_pulse(3);
      end
      send_pixels(np, 1'b0, $urandom_range(0, 3));
      hblank((kind == 3) ? 1 : $urandom_range(1, 40), kind == 2);
      idle($urandom_range(0, 900));
    end

    wait_hpos(400);
    rst_n = 1'b0;
    #1;
    check("reset pixel_color", {25'd0, pixel_color}, 32'd0);
    check("reset pixel_valid", {31'd0, pixel_valid}, 32'd0);
    check("reset force_vsync", {31'd0, force_vsync}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    send_pixels(100, 1'b0, 0);
    idle(900);
    send_pixels(160, 1'b0, 1);
    hblank(20, 1'b0);
    idle(1700);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vga_scan_doubler.md
Name: vga_scan_doubler

Overview:
- Sits between the TIA pixel output and the VGA sync generator / RGB output stage.
- Captures each 160-pixel TIA scanline into a ping-pong line buffer.
- Replays each captured line on two consecutive VGA lines, with every pixel widened 4x (160 -> 640), indexed by the sync generator's hpos/vpos.
- Converts the TIA VSYNC start into the force_vsync request consumed by the sync generator, keeping frames locked.

Parameters:
- SRC_WIDTH, 160, TIA visible pixels per line.
- PIXEL_REPEAT_LOG2, 2, log2 of horizontal pixel repeat (4x).
- COLOR_BITS, 7, TIA palette index width.
- H_DISPLAY, 640, VGA visible width.
- H_MAX, 799, last hpos value of a VGA line.

Ports:
- clk  in  1  system clock, same clock as the sync generator.
- rst_n  in  1  asynchronous active-low reset.
- src_pixel_valid  in  1  TIA pixel strobe, one visible pixel this cycle.
- src_color  in  COLOR_BITS  palette index qualified by src_pixel_valid.
- src_hblank  in  1  TIA horizontal blank level.
- src_vsync  in  1  TIA vertical sync level.
- hpos  in  10  sync generator horizontal position.
- vpos  in  10  sync generator vertical position (observed only, not decoded).
- display_on  in  1  sync generator visible-area flag.
- pixel_color  out  COLOR_BITS  palette index for the current VGA pixel, registered.
- pixel_valid  out  1  pixel_color is displayable (display_on delayed 1 and line_ready).
- force_vsync  out  1  request to the sync generator to jump to vsync.

Behaviour:
- Reset (async, rst_n low): wr_sel=0, rd_sel=0, disp_sel=0, wr_ptr=0, line_ready=0, force_vsync=0, pixel_color=0, pixel_valid=0, edge-detect registers=0. RAM contents are not reset.
- Write side:
  - On src_pixel_valid && !src_hblank && wr_ptr<SRC_WIDTH: write src_color to buffer wr_sel at wr_ptr; wr_ptr+1.
  - Pixels arriving at wr_ptr==SRC_WIDTH are dropped; wr_ptr saturates.
  - Pixels during hblank are ignored.
- Line commit, on src_hblank rising edge (registered edge detect, 1-cycle detect latency):
  - rd_sel<=wr_sel; wr_sel<=~wr_sel; wr_ptr<=0; line_ready<=1.
  - Commit happens even if zero pixels were written.
  - Unwritten entries keep stale contents.
- Read side:
  - At hpos==H_MAX (end of every VGA line), disp_sel<=rd_sel.
  - The displayed buffer never changes mid-line.
  - TIA line period equals two VGA line periods, so each committed line is shown on two VGA lines.
- Read address = hpos >> PIXEL_REPEAT_LOG2, valid when hpos<H_DISPLAY. Address forced to 0 otherwise.
- Output latency: exactly 1 cycle (synchronous RAM read).
  - pixel_color corresponds to the hpos of the previous cycle.
  - pixel_valid <= display_on && line_ready, also delayed 1 cycle.
  - pixel_color <= 0 whenever that delayed qualifier is 0.
- Buffer conflict: if the writer commits twice within one VGA line, disp_sel may equal wr_sel. Tearing within that pair of lines is accepted; no error flag.
- Vsync:
  - On src_vsync rising edge: force_vsync<=1 and wr_ptr<=0. The partially written line is discarded; there is no commit.
  - force_vsync stays high until a cycle with hpos==H_MAX while force_vsync==1, which is the cycle the sync generator samples it. It clears on the following edge.
  - A second src_vsync rise while force_vsync is already high has no extra effect.
- Simultaneous events:
  - src_hblank rise and src_vsync rise in the same cycle: commit performed, force_vsync set, wr_ptr=0.
  - Pixel write in the same cycle as commit: the write goes to the old wr_sel at the old wr_ptr, then the pointer clears.
- Reset mid-line takes effect immediately; outputs drop to 0 asynchronously.

Decomposition:
- Shared package/include vga_timing_pkg:
  - H_DISPLAY, H_MAX, V_DISPLAY, V_SYNC_START.
  - TIA SRC_WIDTH and COLOR_BITS.
  - Shared so the sync generator and this block use one definition.
- Sub-module line_buffer_2p:
  - Simple dual-port RAM, 2*SRC_WIDTH x COLOR_BITS.
  - One write port, one registered read port.
  - Address = {sel, index}.
  - Keeps RAM inference isolated from the control logic.

Test Plan:
- Reset release, no source activity, hpos sweep 0..799 -> pixel_valid=0, pixel_color=0, force_vsync=0 throughout.
- Write 160 pixels with color=index&0x7F, then hblank rise -> on the next VGA line, hpos 0..3 gives color 0 and hpos 636..639 gives color 0x1F (159&0x7F), each 1 cycle late; the same data repeats on the following VGA line.
- Write 200 valid pixels in one line -> only the first 160 stored, wr_ptr saturates; pixel at index 159 displayed at hpos 636..639.
- src_vsync rise at hpos=100 -> force_vsync=1 until the cycle after hpos==799, then 0. A second vsync pulse before clearing does not extend it.
- Commit while hpos=300 -> displayed buffer unchanged for hpos 300..799; new line visible from hpos 0 of the next line.
- Assert rst_n low mid-line at hpos=400 with line_ready=1 -> pixel_color, pixel_valid and force_vsync are 0 in the same cycle; no display until the next commit after release.
